// File: rtl/bounce_pixel_gen_if.sv
// ---------------------------------------------------------------------------
// bounce_pixel_gen_if
//   Bundle between the VGA sync timing block (master side) and the bouncing
//   square pixel generator (slave side).
//
//   master -> slave : p_tick, video_on, x[9:0], y[9:0], hsync_in, vsync_in,
//                     pause
//   slave -> master : rgb[11:0], hsync_out, vsync_out, frame_tick,
//                     bounce_count[7:0]
// ---------------------------------------------------------------------------
interface bounce_pixel_gen_if;
  logic        p_tick;
  logic        video_on;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        hsync_in;
  logic        vsync_in;
  logic        pause;
  logic [11:0] rgb;
  logic        hsync_out;
  logic        vsync_out;
  logic        frame_tick;
  logic [7:0]  bounce_count;

  modport master (
    output p_tick, video_on, x, y, hsync_in, vsync_in, pause,
    input  rgb, hsync_out, vsync_out, frame_tick, bounce_count
  );

  modport slave (
    input  p_tick, video_on, x, y, hsync_in, vsync_in, pause,
    output rgb, hsync_out, vsync_out, frame_tick, bounce_count
  );
endinterface

// File: rtl/bounce_pixel_gen.sv
// ---------------------------------------------------------------------------
// bounce_pixel_gen
//   Draws a solid BOX_SIZE x BOX_SIZE square that moves STEP pixels per frame
//   on each axis and bounces off the four display edges. The sprite position
//   is updated once per frame while the beam is at line V_DISPLAY (vertical
//   blanking), so a visible frame never shows two sprite positions.
//   Pixel colour and the two sync signals are registered together on p_tick,
//   so all three lag their inputs by exactly one pixel period.
//
// Ports
//   clk    in  system clock (4x pixel rate)
//   reset  in  synchronous, active-high
//   bus    slave side of bounce_pixel_gen_if:
//            p_tick, video_on, x, y, hsync_in, vsync_in, pause (in)
//            rgb, hsync_out, vsync_out, frame_tick, bounce_count (out)
// ---------------------------------------------------------------------------
module bounce_pixel_gen #(
  parameter int          H_DISPLAY = 640,
  parameter int          V_DISPLAY = 480,
  parameter int          BOX_SIZE  = 16,
  parameter int          STEP      = 2,
  parameter int          X_INIT    = 0,
  parameter int          Y_INIT    = 0,
  parameter logic [11:0] FG_COLOR  = 12'hF00,
  parameter logic [11:0] BG_COLOR  = 12'h00F
) (
  input  logic               clk,
  input  logic               reset,
  bounce_pixel_gen_if.slave  bus
);

  localparam logic [10:0] BOX_W  = 11'(BOX_SIZE);
  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [9:0]  V_LINE = 10'(V_DISPLAY);

  // Axis index 0 = x, 1 = y. Direction bit 1 = moving towards larger values.
  logic [9:0]  r_pos [2];
  logic [1:0]  r_dir;
  logic [9:0]  w_pos_next [2];
  logic [1:0]  w_dir_next;
  logic [1:0]  w_flip;

  logic        r_frame_tick;
  logic [7:0]  r_bounce_count;
  logic [11:0] r_rgb;
  logic        r_hsync;
  logic        r_vsync;

  // -------------------------------------------------------------------------
  // Per-axis next-position logic. Both axes follow identical rules and only
  // differ in their upper limit (display size minus sprite size).
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_axis
      localparam int          LIMIT = (gi == 0) ? (H_DISPLAY - BOX_SIZE)
                                                : (V_DISPLAY - BOX_SIZE);
      localparam logic [10:0] LIM_W = 11'(LIMIT);

      logic [10:0] w_pos_ext;
      logic [10:0] w_inc;
      logic [9:0]  w_dec;

      // Widened by one bit so pos+STEP near the limit cannot wrap.
      assign w_pos_ext = {1'b0, r_pos[gi]};
      assign w_inc     = w_pos_ext + STEP_W;
      assign w_dec     = r_pos[gi] - STEP_W[9:0];

      // Hitting or overshooting an edge clamps to the edge and reverses.
      assign w_flip[gi] = r_dir[gi] ? (w_inc >= LIM_W) : (w_pos_ext <= STEP_W);

      assign w_pos_next[gi] = r_dir[gi] ? (w_flip[gi] ? LIM_W[9:0] : w_inc[9:0])
                                        : (w_flip[gi] ? 10'd0      : w_dec);

      assign w_dir_next[gi] = r_dir[gi] ^ w_flip[gi];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Sprite hit test, done in 11 bits so pos+BOX_SIZE never wraps.
  // -------------------------------------------------------------------------
  logic [10:0] w_x_ext;
  logic [10:0] w_y_ext;
  logic [10:0] w_box_x;
  logic [10:0] w_box_y;
  logic        w_hit;
  logic        w_frame_point;

  assign w_x_ext = {1'b0, bus.x};
  assign w_y_ext = {1'b0, bus.y};
  assign w_box_x = {1'b0, r_pos[0]};
  assign w_box_y = {1'b0, r_pos[1]};

  assign w_hit = (w_x_ext >= w_box_x) && (w_x_ext < (w_box_x + BOX_W)) &&
                 (w_y_ext >= w_box_y) && (w_y_ext < (w_box_y + BOX_W));

  // First pixel of the first blanking line marks the once-per-frame update.
  assign w_frame_point = bus.p_tick && (bus.x == 10'd0) && (bus.y == V_LINE);

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pos[0]       <= 10'(X_INIT);
      r_pos[1]       <= 10'(Y_INIT);
      r_dir          <= 2'b11;
      r_frame_tick   <= 1'b0;
      r_bounce_count <= 8'd0;
      r_rgb          <= 12'h000;
      r_hsync        <= 1'b0;
      r_vsync        <= 1'b0;
    end else begin
      r_frame_tick <= w_frame_point;

      // Position moves on the clk after the frame point; pause freezes the
      // sprite but the frame_tick pulse itself is unaffected.
      if (r_frame_tick && !bus.pause) begin
        r_pos[0] <= w_pos_next[0];
        r_pos[1] <= w_pos_next[1];
        r_dir    <= w_dir_next;
        // A corner hit flips both axes but counts as a single bounce.
        if (|w_flip) begin
          r_bounce_count <= r_bounce_count + 8'd1;
        end
      end

      if (bus.p_tick) begin
        r_rgb   <= !bus.video_on ? 12'h000 : (w_hit ? FG_COLOR : BG_COLOR);
        r_hsync <= bus.hsync_in;
        r_vsync <= bus.vsync_in;
      end
    end
  end

  assign bus.rgb          = r_rgb;
  assign bus.hsync_out    = r_hsync;
  assign bus.vsync_out    = r_vsync;
  assign bus.frame_tick   = r_frame_tick;
  assign bus.bounce_count = r_bounce_count;

endmodule

// File: tb/tb_bounce_pixel_gen.sv
// ---------------------------------------------------------------------------
// tb_bounce_pixel_gen
//   Four generator instances share one stimulus stream:
//     0 : defaults                         (pixel path, reset, pause)
//     1 : X_INIT=620                        (right-edge bounce)
//     2 : X_INIT=624, Y_INIT=464            (corner hit)
//     3 : 31x31 display, STEP=15            (bounce every frame, count wrap)
//   Stimulus pushes expected pixels / frame results into queues; a monitor
//   on the falling clock edge pops and compares whenever an output updates.
// ---------------------------------------------------------------------------
module tb_bounce_pixel_gen;

  localparam int P_H  [4] = '{640, 640, 640, 31};
  localparam int P_V  [4] = '{480, 480, 480, 31};
  localparam int P_B  [4] = '{16, 16, 16, 16};
  localparam int P_S  [4] = '{2, 2, 2, 15};
  localparam int P_XI [4] = '{0, 620, 624, 0};
  localparam int P_YI [4] = '{0, 0, 464, 0};

  typedef struct {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } px_t;

  typedef struct {
    int id;
    int x;
    int y;
    int c;
  } fr_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       p_tick;
  logic       video_on;
  logic       hs_in;
  logic       vs_in;
  logic [9:0] px;
  logic [9:0] py;
  logic [3:0] pause_v;

  always #5 clk = ~clk;

  bounce_pixel_gen_if bus0 ();
  bounce_pixel_gen_if bus1 ();
  bounce_pixel_gen_if bus2 ();
  bounce_pixel_gen_if bus3 ();

  assign bus0.p_tick = p_tick; assign bus0.video_on = video_on; assign bus0.x = px; assign bus0.y = py;
  assign bus0.hsync_in = hs_in; assign bus0.vsync_in = vs_in; assign bus0.pause = pause_v[0];
  assign bus1.p_tick = p_tick; assign bus1.video_on = video_on; assign bus1.x = px; assign bus1.y = py;
  assign bus1.hsync_in = hs_in; assign bus1.vsync_in = vs_in; assign bus1.pause = pause_v[1];
  assign bus2.p_tick = p_tick; assign bus2.video_on = video_on; assign bus2.x = px; assign bus2.y = py;
  assign bus2.hsync_in = hs_in; assign bus2.vsync_in = vs_in; assign bus2.pause = pause_v[2];
  assign bus3.p_tick = p_tick; assign bus3.video_on = video_on; assign bus3.x = px; assign bus3.y = py;
  assign bus3.hsync_in = hs_in; assign bus3.vsync_in = vs_in; assign bus3.pause = pause_v[3];

  bounce_pixel_gen u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
  bounce_pixel_gen #(.X_INIT(620)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
  bounce_pixel_gen #(.X_INIT(624), .Y_INIT(464)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));
  bounce_pixel_gen #(.H_DISPLAY(31), .V_DISPLAY(31), .STEP(15)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3));

  // Observed sprite state
  logic [9:0] obs_x [4];
  logic [9:0] obs_y [4];
  logic [7:0] obs_c [4];
  logic [3:0] obs_ft;

  assign obs_x[0] = u_dut0.r_pos[0]; assign obs_y[0] = u_dut0.r_pos[1];
  assign obs_x[1] = u_dut1.r_pos[0]; assign obs_y[1] = u_dut1.r_pos[1];
  assign obs_x[2] = u_dut2.r_pos[0]; assign obs_y[2] = u_dut2.r_pos[1];
  assign obs_x[3] = u_dut3.r_pos[0]; assign obs_y[3] = u_dut3.r_pos[1];
  assign obs_c[0] = bus0.bounce_count; assign obs_ft[0] = bus0.frame_tick;
  assign obs_c[1] = bus1.bounce_count; assign obs_ft[1] = bus1.frame_tick;
  assign obs_c[2] = bus2.bounce_count; assign obs_ft[2] = bus2.frame_tick;
  assign obs_c[3] = bus3.bounce_count; assign obs_ft[3] = bus3.frame_tick;

  int  n_checks = 0;
  int  n_err    = 0;
  px_t pq [$];
  fr_t fq [$];

  // Reference model state
  int m_x [4], m_y [4], m_dx [4], m_dy [4], m_c [4];
  // Monitor state
  int s_x [4], s_y [4], s_c [4], ft_cnt [4];
  bit pend [4];
  px_t last_px;
  logic rst_q, ptick_q;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic axis_step(input int pos, input int dir, input int lim, input int s,
                           output int npos, output int ndir, output bit flip);
    flip = 1'b0; npos = pos; ndir = dir;
    if (dir > 0) begin
      if (pos + s >= lim) begin npos = lim; ndir = -1; flip = 1'b1; end
      else npos = pos + s;
    end else begin
      if (pos <= s) begin npos = 0; ndir = 1; flip = 1'b1; end
      else npos = pos - s;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_x[i] = P_XI[i]; m_y[i] = P_YI[i]; m_dx[i] = 1; m_dy[i] = 1; m_c[i] = 0;
    end
  endtask

  task automatic model_frame(input int id);
    int nx, ny, ndx, ndy;
    bit fx, fy;
    fr_t e;
    if (pause_v[id] == 1'b0) begin
      axis_step(m_x[id], m_dx[id], P_H[id] - P_B[id], P_S[id], nx, ndx, fx);
      axis_step(m_y[id], m_dy[id], P_V[id] - P_B[id], P_S[id], ny, ndy, fy);
      m_x[id] = nx; m_dx[id] = ndx; m_y[id] = ny; m_dy[id] = ndy;
      if (fx || fy) m_c[id] = (m_c[id] + 1) % 256;
    end
    e.id = id; e.x = m_x[id]; e.y = m_y[id]; e.c = m_c[id];
    fq.push_back(e);
  endtask

  // One pixel period: new inputs, three idle clks, then p_tick for one clk.
  task automatic pix(input int xx, input int yy, input bit von, input bit hsv, input bit vsv);
    px_t e;
    bit  hit;
    @(negedge clk);
    p_tick = 1'b0; px = 10'(xx); py = 10'(yy); video_on = von; hs_in = hsv; vs_in = vsv;
    repeat (2) @(negedge clk);
    hit = (xx >= m_x[0]) && (xx < m_x[0] + 16) && (yy >= m_y[0]) && (yy < m_y[0] + 16);
    e.rgb = !von ? 12'h000 : (hit ? 12'hF00 : 12'h00F);
    e.hs = hsv; e.vs = vsv;
    pq.push_back(e);
    @(negedge clk);
    p_tick = 1'b1;
    if (xx == 0) begin
      for (int i = 0; i < 4; i++) if (yy == P_V[i]) model_frame(i);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      p_tick = 1'b0;
    end
  endtask

  task automatic frame480();
    pix(0, 480, 0, 0, 1);
    idle(3);
  endtask

  task automatic chk_pos(input int id, input int ex, input int ey, input int ec);
    chk($sformatf("pos_x[%0d]", id), int'(obs_x[id]), ex);
    chk($sformatf("pos_y[%0d]", id), int'(obs_y[id]), ey);
    chk($sformatf("bounce_count[%0d]", id), int'(obs_c[id]), ec);
  endtask

  // Reset held for 3 clks in the middle of a visible line, p_tick toggling.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; px = 10'd320; py = 10'd200; video_on = 1'b1; hs_in = 1'b1; vs_in = 1'b1;
    p_tick = 1'b1;
    @(negedge clk); p_tick = 1'b0;
    @(negedge clk); p_tick = 1'b1;
    @(negedge clk); reset = 1'b0; p_tick = 1'b0;
    model_reset();
  endtask

  always @(posedge clk) begin
    rst_q   <= reset;
    ptick_q <= p_tick;
  end

  // ---------------------------------------------------------------- monitor
  always @(negedge clk) begin
    px_t e;
    fr_t f;
    if (rst_q === 1'b1) begin
      chk("reset_rgb", int'(bus0.rgb), 0);
      chk("reset_hsync", int'(bus0.hsync_out), 0);
      chk("reset_vsync", int'(bus0.vsync_out), 0);
      last_px.rgb = 12'h000; last_px.hs = 1'b0; last_px.vs = 1'b0;
    end else if (ptick_q === 1'b1) begin
      if (pq.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL pix_unexpected: actual=output update required=none");
      end else begin
        e = pq.pop_front();
        chk("pix_rgb", int'(bus0.rgb), int'(e.rgb));
        chk("pix_hsync", int'(bus0.hsync_out), int'(e.hs));
        chk("pix_vsync", int'(bus0.vsync_out), int'(e.vs));
        last_px = e;
      end
    end else begin
      chk("hold_rgb", int'(bus0.rgb), int'(last_px.rgb));
      chk("hold_hsync", int'(bus0.hsync_out), int'(last_px.hs));
      chk("hold_vsync", int'(bus0.vsync_out), int'(last_px.vs));
    end

    for (int i = 0; i < 4; i++) begin
      if (rst_q === 1'b1) begin
        s_x[i] = P_XI[i]; s_y[i] = P_YI[i]; s_c[i] = 0; pend[i] = 1'b0;
        chk($sformatf("reset_x[%0d]", i), int'(obs_x[i]), s_x[i]);
        chk($sformatf("reset_y[%0d]", i), int'(obs_y[i]), s_y[i]);
        chk($sformatf("reset_count[%0d]", i), int'(obs_c[i]), 0);
        chk($sformatf("reset_frame_tick[%0d]", i), int'(obs_ft[i]), 0);
      end else if (pend[i]) begin
        pend[i] = 1'b0;
        if (fq.size() == 0 || fq[0].id != i) begin
          n_checks++; n_err++;
          $display("FAIL frame_unexpected[%0d]: actual=frame_tick required=none", i);
        end else begin
          f = fq.pop_front();
          s_x[i] = f.x; s_y[i] = f.y; s_c[i] = f.c;
          chk($sformatf("frame_x[%0d]", i), int'(obs_x[i]), s_x[i]);
          chk($sformatf("frame_y[%0d]", i), int'(obs_y[i]), s_y[i]);
          chk($sformatf("frame_count[%0d]", i), int'(obs_c[i]), s_c[i]);
          chk($sformatf("range_x[%0d]", i), (int'(obs_x[i]) <= P_H[i] - P_B[i]) ? 1 : 0, 1);
          chk($sformatf("range_y[%0d]", i), (int'(obs_y[i]) <= P_V[i] - P_B[i]) ? 1 : 0, 1);
        end
      end else begin
        chk($sformatf("hold_x[%0d]", i), int'(obs_x[i]), s_x[i]);
        chk($sformatf("hold_y[%0d]", i), int'(obs_y[i]), s_y[i]);
        chk($sformatf("hold_count[%0d]", i), int'(obs_c[i]), s_c[i]);
      end
      if (obs_ft[i] === 1'b1) begin
        pend[i] = 1'b1;
        ft_cnt[i]++;
      end
    end
  end

  // --------------------------------------------------------------- stimulus
  initial begin
    int snap;
    reset = 1'b1; p_tick = 1'b0; video_on = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
    px = 10'd0; py = 10'd0; pause_v = 4'b0000;
    for (int i = 0; i < 4; i++) begin ft_cnt[i] = 0; pend[i] = 1'b0; end
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(2);
    chk("init_rgb", int'(bus0.rgb), 0);
    chk("init_count", int'(bus0.bounce_count), 0);

    // Pixel path, sprite at (0,0)
    pix(0, 0, 1, 0, 0);      // F00
    pix(15, 15, 1, 1, 0);    // F00, last sprite pixel
    pix(16, 0, 1, 0, 1);     // 00F
    pix(0, 16, 1, 1, 1);     // 00F
    pix(700, 10, 0, 0, 0);   // 000, outside visible area
    idle(2);

    // Right-edge bounce (inst 1) and corner hit (inst 2)
    frame480();
    chk_pos(0, 2, 2, 0);
    chk_pos(1, 622, 2, 0);
    chk_pos(2, 624, 464, 1);
    frame480();
    chk_pos(1, 624, 4, 1);
    chk_pos(2, 622, 462, 1);
    frame480();
    chk_pos(0, 6, 6, 0);
    chk_pos(1, 622, 6, 1);
    chk_pos(2, 620, 460, 1);

    // Sprite moved to (6,6)
    pix(5, 6, 1, 0, 0);      // 00F
    pix(6, 6, 1, 1, 0);      // F00
    pix(21, 21, 1, 0, 1);    // F00
    pix(22, 21, 1, 1, 1);    // 00F
    pix(21, 22, 1, 0, 0);    // 00F
    pix(639, 479, 1, 1, 0);  // 00F
    idle(2);

    // Pause on inst 0
    pause_v[0] = 1'b1;
    snap = ft_cnt[0];
    frame480();
    frame480();
    frame480();
    chk("pause_frame_ticks", ft_cnt[0] - snap, 3);
    chk_pos(0, 6, 6, 0);
    pause_v[0] = 1'b0;
    frame480();
    chk_pos(0, 8, 8, 0);

    // Inst 3 bounces (corner) every frame: count wraps after 256 frames
    for (int k = 0; k < 255; k++) pix(0, 31, 0, 0, 1);
    idle(3);
    chk_pos(3, 15, 15, 255);
    pix(0, 31, 0, 0, 1);
    idle(3);
    chk_pos(3, 0, 0, 0);

    // Mid-line reset with non-zero outputs
    pix(10, 10, 1, 1, 1);    // F00, sprite at (8,8)
    idle(1);
    do_reset();
    idle(2);
    chk("midreset_rgb", int'(bus0.rgb), 0);
    chk("midreset_hsync", int'(bus0.hsync_out), 0);
    chk_pos(0, 0, 0, 0);
    chk_pos(1, 620, 0, 0);
    pix(0, 0, 1, 0, 0);      // F00, sprite back at origin
    frame480();
    chk_pos(0, 2, 2, 0);
    chk_pos(1, 622, 2, 0);
    chk_pos(2, 624, 464, 1);

    idle(4);
    chk("pixel_queue_empty", pq.size(), 0);
    chk("frame_queue_empty", fq.size(), 0);
    chk("frame_ticks_inst0", ft_cnt[0], 8);
    chk("frame_ticks_inst3", ft_cnt[3], 256);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
